// File: rtl/lpif_ll_credit_txrx.sv
// lpif_ll_credit_txrx: credit-gated TX path plus FWFT RX FIFO with credit return.
// Macro LPIF_LL_CREDIT_EN enables the credit counter and credit-return pulses.
module lpif_ll_credit_txrx #(
  parameter int DATA_W   = 1124,
  parameter int RX_DEPTH = 16,
  parameter int CREDIT_W = 8
) (
  input  logic                clk_wr,
  input  logic                rst_wr_n,
  input  logic                tx_online,
  input  logic                rx_online,
  input  logic [CREDIT_W-1:0] init_downstream_credit,
  input  logic [DATA_W-1:0]   user_tx_data,
  input  logic                user_tx_valid,
  output logic                user_tx_ready,
  output logic [DATA_W-1:0]   tx_phy_data,
  output logic                tx_phy_push,
  output logic                tx_phy_credit_return,
  input  logic [DATA_W-1:0]   rx_phy_data,
  input  logic                rx_phy_push,
  input  logic                rx_phy_credit_return,
  output logic [DATA_W-1:0]   user_rx_data,
  output logic                user_rx_valid,
  input  logic                user_rx_ready,
  output logic [31:0]         debug_status
);
  localparam int AW = $clog2(RX_DEPTH);
  typedef enum logic [1:0] {TX_OFF = 2'd0, TX_LOAD = 2'd1, TX_ON = 2'd2} tx_state_e;
  tx_state_e state_q, state_d;
  logic push_q, push_d;
  logic [DATA_W-1:0] txd_q, txd_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic rx_ovf_q, rx_ovf_d;
  logic [DATA_W-1:0] mem_q [RX_DEPTH];
  logic xfer, pop, full, wr;
  logic [7:0] credit8;
  logic credit_ovf;
  always_comb begin
    state_d = !tx_online ? TX_OFF : (state_q == TX_OFF ? TX_LOAD : TX_ON);
    xfer    = user_tx_valid && user_tx_ready;
    push_d  = xfer;
    txd_d   = xfer ? user_tx_data : txd_q;
  end
`ifdef LPIF_LL_CREDIT_EN
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic cov_q, cov_d, cr_q, cr_d, ret;
  assign user_tx_ready = state_q == TX_ON && credit_q != '0;
  assign ret = rx_phy_credit_return && state_q == TX_ON;
  always_comb begin
    credit_d = credit_q;
    cov_d    = cov_q;
    cr_d     = pop;
    if (!tx_online) credit_d = '0;
    else if (state_q == TX_LOAD) credit_d = init_downstream_credit;
    else if (xfer && !ret) credit_d = credit_q - CREDIT_W'(1);
    else if (ret && !xfer) begin
      if (&credit_q) cov_d = 1'b1;
      else credit_d = credit_q + CREDIT_W'(1);
    end
  end
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      credit_q <= '0;
      cov_q    <= 1'b0;
      cr_q     <= 1'b0;
    end else begin
      credit_q <= credit_d;
      cov_q    <= cov_d;
      cr_q     <= cr_d;
    end
  end
  assign tx_phy_credit_return = cr_q;
  assign credit8    = 8'(credit_q);
  assign credit_ovf = cov_q;
`else
  logic unused_credit;
  assign unused_credit = ^{init_downstream_credit, rx_phy_credit_return};
  // Gated by reset so the ready output is low while reset is held.
  assign user_tx_ready = tx_online && rst_wr_n;
  assign tx_phy_credit_return = 1'b0;
  assign credit8    = 8'd0;
  assign credit_ovf = 1'b0;
`endif
  always_comb begin
    pop      = cnt_q != '0 && user_rx_ready;
    full     = cnt_q == (AW+1)'(RX_DEPTH);
    wr       = rx_online && rx_phy_push && (!full || pop);
    wptr_d   = !rx_online ? '0 : wptr_q + AW'(wr);
    rptr_d   = !rx_online ? '0 : rptr_q + AW'(pop);
    cnt_d    = !rx_online ? '0 : cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    rx_ovf_d = rx_ovf_q | (rx_online && rx_phy_push && full && !pop);
  end
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q  <= TX_OFF;
      push_q   <= 1'b0;
      txd_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rx_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      push_q   <= push_d;
      txd_q    <= txd_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end
  always_ff @(posedge clk_wr) begin
    if (wr) mem_q[wptr_q] <= rx_phy_data;
  end
  assign tx_phy_push   = push_q;
  assign tx_phy_data   = txd_q;
  assign user_rx_valid = cnt_q != '0;
  assign user_rx_data  = mem_q[rptr_q];
  assign debug_status  = {credit8, 8'(cnt_q), state_q, rx_online, 11'd0, rx_ovf_q, credit_ovf};
endmodule

// File: tb/tb_lpif_ll_credit_txrx.sv
// tb_lpif_ll_credit_txrx: directed checks of credit TX path and RX FIFO.
module tb_lpif_ll_credit_txrx;
`ifdef LPIF_LL_CREDIT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, tx_online, rx_online, user_tx_valid, user_tx_ready, tx_phy_push, tx_phy_credit_return;
  logic rx_phy_push, rx_phy_credit_return, user_rx_valid, user_rx_ready;
  logic [7:0] init_credit;
  logic [15:0] user_tx_data, tx_phy_data, rx_phy_data, user_rx_data;
  logic [31:0] debug_status;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  lpif_ll_credit_txrx #(.DATA_W(16), .RX_DEPTH(4), .CREDIT_W(8)) dut (
    .clk_wr(clk), .rst_wr_n(rst_n), .tx_online(tx_online), .rx_online(rx_online),
    .init_downstream_credit(init_credit), .user_tx_data(user_tx_data),
    .user_tx_valid(user_tx_valid), .user_tx_ready(user_tx_ready),
    .tx_phy_data(tx_phy_data), .tx_phy_push(tx_phy_push),
    .tx_phy_credit_return(tx_phy_credit_return), .rx_phy_data(rx_phy_data),
    .rx_phy_push(rx_phy_push), .rx_phy_credit_return(rx_phy_credit_return),
    .user_rx_data(user_rx_data), .user_rx_valid(user_rx_valid),
    .user_rx_ready(user_rx_ready), .debug_status(debug_status)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] last;
    logic rdy;
    rst_n = 0; tx_online = 1; rx_online = 1; init_credit = 8'd3;
    user_tx_valid = 0; user_tx_data = 0; rx_phy_push = 0; rx_phy_data = 0;
    rx_phy_credit_return = 0; user_rx_ready = 0;
    #1;
    chk("rst_ready", user_tx_ready, 0);
    chk("rst_push", tx_phy_push, 0);
    chk("rst_data", tx_phy_data, 0);
    chk("rst_cr", tx_phy_credit_return, 0);
    chk("rst_rxv", user_rx_valid, 0);
    chk("rst_dbg", debug_status, 32'h0000_2000);
    @(negedge clk); rst_n = 1;
    step; chk("st_load", debug_status[15:14], 1);
    step; chk("st_on", debug_status[15:14], 2);
    chk("credit_init", debug_status[31:24], EN ? 3 : 0);
    chk("ready_on", user_tx_ready, 1);
    last = 0;
    for (int i = 0; i < 5; i++) begin
      user_tx_valid = 1; user_tx_data = 16'h100 + 16'(i);
      rdy = EN ? (i < 3) : 1'b1;
      chk("tx_ready", user_tx_ready, rdy);
      step;
      if (rdy) last = 16'h100 + 16'(i);
      chk("tx_push", tx_phy_push, rdy);
      chk("tx_data", tx_phy_data, last);
    end
    user_tx_valid = 0;
    step;
    chk("tx_idle_push", tx_phy_push, 0);
    chk("tx_hold", tx_phy_data, EN ? 16'h102 : 16'h104);
    chk("credit_zero", debug_status[31:24], 0);
    chk("ready_nocred", user_tx_ready, EN ? 0 : 1);
    rx_phy_credit_return = 1; step; rx_phy_credit_return = 0;
    chk("credit_ret", debug_status[31:24], EN ? 1 : 0);
    chk("ready_ret", user_tx_ready, 1);
    user_tx_valid = 1; user_tx_data = 16'h200; rx_phy_credit_return = 1;
    step; user_tx_valid = 0; rx_phy_credit_return = 0;
    chk("credit_both", debug_status[31:24], EN ? 1 : 0);
    chk("ready_both", user_tx_ready, 1);
    chk("push_both", tx_phy_push, 1);
    tx_online = 0; step;
    chk("st_off", debug_status[15:14], 0);
    chk("credit_off", debug_status[31:24], 0);
    chk("ready_off", user_tx_ready, 0);
    init_credit = 8'hFF; tx_online = 1; step; step;
    chk("credit_max", debug_status[31:24], EN ? 8'hFF : 0);
    chk("cov_clear", debug_status[0], 0);
    rx_phy_credit_return = 1; step; rx_phy_credit_return = 0;
    chk("credit_sat", debug_status[31:24], EN ? 8'hFF : 0);
    chk("cov_set", debug_status[0], EN);
    for (int i = 0; i < 5; i++) begin
      rx_phy_push = 1; rx_phy_data = 16'hA0 + 16'(i);
      step;
      chk("rx_cnt", debug_status[23:16], i < 4 ? i + 1 : 4);
      chk("rx_ovf", debug_status[1], i == 4);
      chk("rx_fwft", user_rx_data, 16'hA0);
    end
    rx_phy_push = 0;
    chk("rx_valid_full", user_rx_valid, 1);
    user_rx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("pop_valid", user_rx_valid, 1);
      chk("pop_data", user_rx_data, 16'hA0 + 16'(i));
      chk("pop_cr", tx_phy_credit_return, EN && i > 0);
      step;
    end
    chk("fifth_absent", user_rx_valid, 0);
    chk("last_cr", tx_phy_credit_return, EN);
    user_rx_ready = 0; step;
    chk("cr_done", tx_phy_credit_return, 0);
    chk("rx_empty", debug_status[23:16], 0);
    for (int i = 0; i < 4; i++) begin
      rx_phy_push = 1; rx_phy_data = 16'hB0 + 16'(i); step;
    end
    rx_phy_push = 0;
    chk("refill_cnt", debug_status[23:16], 4);
    rx_phy_push = 1; rx_phy_data = 16'hB4; user_rx_ready = 1;
    step; rx_phy_push = 0;
    chk("fullpop_cnt", debug_status[23:16], 4);
    chk("fullpop_data", user_rx_data, 16'hB1);
    step; user_rx_ready = 0; step;
    chk("three_cnt", debug_status[23:16], 3);
    chk("three_data", user_rx_data, 16'hB2);
    chk("three_cr", tx_phy_credit_return, 0);
    rx_online = 0; step;
    chk("flush_cnt", debug_status[23:16], 0);
    chk("flush_valid", user_rx_valid, 0);
    chk("flush_cr", tx_phy_credit_return, 0);
    step;
    chk("flush_cr2", tx_phy_credit_return, 0);
    rx_online = 1; rx_phy_push = 1; rx_phy_data = 16'hC0; step; rx_phy_push = 0;
    chk("after_flush_v", user_rx_valid, 1);
    chk("after_flush_d", user_rx_data, 16'hC0);
    user_tx_valid = 1; user_tx_data = 16'h300; user_rx_ready = 1;
    step;
    chk("mid_push", tx_phy_push, 1);
    chk("mid_cr", tx_phy_credit_return, EN);
    #2 rst_n = 0;
    #1;
    chk("mrst_ready", user_tx_ready, 0);
    chk("mrst_push", tx_phy_push, 0);
    chk("mrst_data", tx_phy_data, 0);
    chk("mrst_cr", tx_phy_credit_return, 0);
    chk("mrst_rxv", user_rx_valid, 0);
    chk("mrst_dbg", debug_status, 32'h0000_2000);
    user_tx_valid = 0; user_rx_ready = 0;
    @(negedge clk); rst_n = 1;
    step;
    chk("rel_load", debug_status[15:14], 1);
    chk("rel_ready_load", user_tx_ready, EN ? 0 : 1);
    step;
    chk("rel_on", debug_status[15:14], 2);
    chk("rel_ready_on", user_tx_ready, 1);
    chk("rel_push", tx_phy_push, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
